// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller: E/M/W tag pipeline, bypass selects, load-use/PC stalls, flushes.
// Latency: selects/stalls/flushes are same-cycle combinational, tags move 1 stage/cycle; no backpressure input.
module hazard_fwd_unit #(
  parameter int NSRC   = 2,
  parameter int RW     = 4,
  parameter int PC_IDX = 15,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC*RW-1:0]   SrcD,
  input  logic [NSRC-1:0]      SrcValidD,
  input  logic [RW-1:0]        WA3D,
  input  logic                 RegWriteD,
  input  logic                 MemtoRegD,
  input  logic                 PCSrcD,
  input  logic                 BranchTakenE,
  output logic [2*NSRC-1:0]    ForwardE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 PCSrcW,
  output logic [CNT_W-1:0]     StallCount
);

  localparam logic [RW-1:0] PC_REG = RW'(PC_IDX);

  typedef struct packed {
    logic          reg_write;
    logic          pc_src;
    logic [RW-1:0] wa3;
  } tag_t;

  tag_t               tag_d;
  tag_t               tag_e;
  tag_t               tag_m;
  tag_t               tag_w;
  logic               mem_to_reg_e;
  logic [NSRC*RW-1:0] src_e;
  logic [NSRC-1:0]    src_vld_e;
  logic [CNT_W-1:0]   stall_cnt;
  logic               ldrstall;
  logic               pcwrpend;
  logic               stall;

  assign tag_d = '{reg_write: RegWriteD, pc_src: PCSrcD, wa3: WA3D};

  // The load flag is only consulted in E (load-use check), so it is not carried further.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_e        <= '0;
      tag_m        <= '0;
      tag_w        <= '0;
      mem_to_reg_e <= 1'b0;
      src_e        <= '0;
      src_vld_e    <= '0;
    end else begin
      if (FlushE) begin
        tag_e        <= '{reg_write: 1'b0, pc_src: 1'b0, wa3: WA3D};
        mem_to_reg_e <= 1'b0;
        src_vld_e    <= '0;
      end else begin
        tag_e        <= tag_d;
        mem_to_reg_e <= MemtoRegD;
        src_vld_e    <= SrcValidD;
      end
      src_e <= SrcD;
      tag_m <= tag_e;
      tag_w <= tag_m;
    end
  end

  // M has priority over W; PC reads always come from the regfile path.
  always_comb begin
    logic [RW-1:0] src_i;
    src_i    = '0;
    ForwardE = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_i = src_e[i*RW +: RW];
      if (src_vld_e[i] && (src_i != PC_REG)) begin
        if (tag_m.reg_write && (tag_m.wa3 == src_i)) begin
          ForwardE[2*i +: 2] = 2'b10;
        end else if (tag_w.reg_write && (tag_w.wa3 == src_i)) begin
          ForwardE[2*i +: 2] = 2'b01;
        end
      end
    end
  end

  always_comb begin
    logic [RW-1:0] src_i;
    logic          hit;
    src_i = '0;
    hit   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      src_i = SrcD[i*RW +: RW];
      if (SrcValidD[i] && (src_i == tag_e.wa3) && (src_i != PC_REG)) begin
        hit = 1'b1;
      end
    end
    ldrstall = tag_e.reg_write && mem_to_reg_e && hit;
  end

  assign pcwrpend = PCSrcD | tag_e.pc_src | tag_m.pc_src;
  // A taken branch redirects fetch, so a pending load-use stall is moot.
  assign stall    = ldrstall & ~BranchTakenE;

  assign StallD = stall;
  assign StallF = stall | pcwrpend;
  assign FlushD = pcwrpend | tag_w.pc_src | BranchTakenE;
  assign FlushE = ldrstall | BranchTakenE;
  assign PCSrcW = tag_w.pc_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (StallF && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign StallCount = stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed cycle table, hand sequences, random vs. model.
module tb_hazard_fwd_unit;

  logic        clk;
  logic        reset;
  logic [7:0]  SrcD;
  logic [1:0]  SrcValidD;
  logic [3:0]  WA3D;
  logic        RegWriteD, MemtoRegD, PCSrcD, BranchTakenE;
  logic [3:0]  ForwardE, ForwardE2;
  logic        StallF, StallD, FlushD, FlushE, PCSrcW;
  logic        StallF2, StallD2, FlushD2, FlushE2, PCSrcW2;
  logic [15:0] StallCount;
  logic [1:0]  StallCount2;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_fwd_unit #(.NSRC(2), .RW(4), .PC_IDX(15), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .SrcD(SrcD), .SrcValidD(SrcValidD), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCSrcW(PCSrcW), .StallCount(StallCount)
  );

  hazard_fwd_unit #(.NSRC(2), .RW(4), .PC_IDX(15), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .SrcD(SrcD), .SrcValidD(SrcValidD), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
    .ForwardE(ForwardE2), .StallF(StallF2), .StallD(StallD2), .FlushD(FlushD2), .FlushE(FlushE2),
    .PCSrcW(PCSrcW2), .StallCount(StallCount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  s0, s1;
    logic [1:0]  sv;
    logic [3:0]  wa3;
    logic        rw, mr, pcs, bt;
    logic [3:0]  fwd;
    logic        sf, sd, fd, fe, pw;
    logic [15:0] cnt;
  } vec_t;

  typedef struct packed {
    logic       rw, mr, pcs;
    logic [3:0] wa3;
    logic [1:0][3:0] src;
    logic [1:0] sv;
  } ins_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] s0, s1, input logic [1:0] sv, input logic [3:0] wa3,
                     input logic rw, mr, pcs, bt, input logic [3:0] fwd,
                     input logic sf, sd, fd, fe, pw, input logic [15:0] cnt);
    vec_t v;
    v = '{s0: s0, s1: s1, sv: sv, wa3: wa3, rw: rw, mr: mr, pcs: pcs, bt: bt,
          fwd: fwd, sf: sf, sd: sd, fd: fd, fe: fe, pw: pw, cnt: cnt};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] s0, s1, input logic [1:0] sv, input logic [3:0] wa3,
                       input logic rw, mr, pcs, bt);
    SrcD = {s1, s0}; SrcValidD = sv; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = mr; PCSrcD = pcs; BranchTakenE = bt;
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] fwd, input logic sf, sd, fd, fe, pw,
                          input logic [15:0] cnt);
    chk({tag, "_fwd"}, 32'(ForwardE), 32'(fwd));
    chk({tag, "_stallf"}, 32'(StallF), 32'(sf));
    chk({tag, "_stalld"}, 32'(StallD), 32'(sd));
    chk({tag, "_flushd"}, 32'(FlushD), 32'(fd));
    chk({tag, "_flushe"}, 32'(FlushE), 32'(fe));
    chk({tag, "_pcsrcw"}, 32'(PCSrcW), 32'(pw));
    chk({tag, "_cnt"}, 32'(StallCount), 32'(cnt));
  endtask

  function automatic logic [3:0] rnd_reg();
    logic [3:0] r;
    r = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    ins_t me, mm, mw, d, ne;
    int   mcnt, mcnt2;
    logic [3:0] efwd;
    logic ld, pend, est, rst_now;

    reset = 1'b1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
    #1;
    chk_outs("reset", 4'b0000, 0, 0, 0, 0, 0, 16'd0);
    chk("reset_cnt_sat", 32'(StallCount2), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    //   s0  s1  sv     wa3 rw mr pcs bt | fwd     sf sd fd fe pw cnt
    add(0,  0,  2'b00, 0,  0, 0, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 0);  // idle
    add(0,  0,  2'b00, 1,  1, 0, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 0);  // ADD r1
    add(1,  4,  2'b11, 2,  1, 0, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 0);  // SUB r2,r1,r4
    add(0,  1,  2'b10, 0,  0, 0, 0, 0,   4'b0010, 0, 0, 0, 0, 0, 0);  // op0 from M
    add(0,  0,  2'b00, 0,  0, 0, 0, 0,   4'b0100, 0, 0, 0, 0, 0, 0);  // op1 from W
    add(0,  0,  2'b00, 3,  1, 1, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 0);  // LDR r3
    add(3,  0,  2'b01, 4,  1, 0, 0, 0,   4'b0000, 1, 1, 0, 1, 0, 0);  // load-use stall
    add(3,  0,  2'b01, 4,  1, 0, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 1);  // held, bubble in E
    add(0,  0,  2'b00, 0,  0, 0, 0, 0,   4'b0001, 0, 0, 0, 0, 0, 1);  // load data from W
    add(0,  0,  2'b00, 15, 1, 0, 1, 0,   4'b0000, 1, 0, 1, 0, 0, 1);  // PC write in D
    add(0,  0,  2'b00, 0,  0, 0, 0, 0,   4'b0000, 1, 0, 1, 0, 0, 2);  // in E
    add(0,  0,  2'b00, 0,  0, 0, 0, 0,   4'b0000, 1, 0, 1, 0, 0, 3);  // in M
    add(0,  0,  2'b00, 0,  0, 0, 0, 0,   4'b0000, 0, 0, 1, 0, 1, 4);  // in W
    add(0,  0,  2'b00, 5,  1, 1, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 4);  // LDR r5
    add(0,  5,  2'b10, 0,  0, 0, 0, 1,   4'b0000, 0, 0, 1, 1, 0, 4);  // hazard + taken branch
    add(0,  0,  2'b00, 0,  0, 0, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 4);
    add(0,  0,  2'b00, 15, 1, 0, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 4);  // writes r15
    add(15, 15, 2'b11, 0,  0, 0, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 4);
    add(15, 0,  2'b01, 0,  0, 0, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 4);  // r15 vs M: no fwd
    add(0,  0,  2'b00, 15, 1, 1, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 4);  // r15 vs W; LDR r15
    add(15, 0,  2'b01, 0,  0, 0, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 4);  // no load-use on r15
    add(0,  0,  2'b00, 0,  0, 0, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 4);
    add(0,  0,  2'b00, 6,  1, 1, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 4);  // LDR r6
    add(6,  0,  2'b01, 0,  0, 0, 1, 0,   4'b0000, 1, 1, 1, 1, 0, 4);  // load-use + PC write
    add(0,  0,  2'b00, 0,  0, 0, 0, 0,   4'b0000, 0, 0, 0, 0, 0, 5);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].s0, vecs[i].s1, vecs[i].sv, vecs[i].wa3,
            vecs[i].rw, vecs[i].mr, vecs[i].pcs, vecs[i].bt);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].fwd, vecs[i].sf, vecs[i].sd,
               vecs[i].fd, vecs[i].fe, vecs[i].pw, vecs[i].cnt);
    end

    // Constant PC-write stall: wide counter counts, 2-bit counter saturates at 3.
    do_reset();
    drive(0, 0, 2'b00, 15, 1, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("sat_cnt16_%0d", k), 32'(StallCount), 32'(k));
      chk($sformatf("sat_cnt2_%0d", k), 32'(StallCount2), 32'((k > 3) ? 3 : k));
    end

    // Reset in the middle of a load-use stall.
    drive(0, 0, 2'b00, 7, 1, 1, 0, 0);
    @(negedge clk);
    drive(7, 0, 2'b01, 0, 0, 0, 0, 0);
    #1;
    chk("mid_pre_stalld", 32'(StallD), 32'd1);
    reset = 1'b1;
    #1;
    chk_outs("mid_rst", 4'b0000, 0, 0, 0, 0, 0, 16'd0);
    chk("mid_rst_cnt2", 32'(StallCount2), 32'd0);
    PCSrcD = 1'b1;
    #1;
    chk("mid_rst_pcsrcd_stallf", 32'(StallF), 32'd1);
    chk("mid_rst_pcsrcd_flushd", 32'(FlushD), 32'd1);
    PCSrcD = 1'b0;
    #1;
    reset = 1'b0;
    @(negedge clk);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_fwd_m_cleared", 32'(ForwardE), 32'd0);

    // Randomized run against a stage-list model.
    do_reset();
    me = '0; mm = '0; mw = '0; mcnt = 0; mcnt2 = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst_now = ($urandom_range(0, 59) == 0);
      d.src[0] = rnd_reg();
      d.src[1] = rnd_reg();
      d.sv     = 2'($urandom_range(0, 3));
      d.wa3    = rnd_reg();
      d.rw     = ($urandom_range(0, 1) == 0);
      d.mr     = d.rw && ($urandom_range(0, 2) == 0);
      d.pcs    = ($urandom_range(0, 9) == 0);
      reset    = rst_now;
      drive(d.src[0], d.src[1], d.sv, d.wa3, d.rw, d.mr, d.pcs, ($urandom_range(0, 7) == 0));
      if (rst_now) begin
        me = '0; mm = '0; mw = '0; mcnt = 0; mcnt2 = 0;
      end
      #1;
      efwd = '0;
      for (int i = 0; i < 2; i++) begin
        if (me.sv[i] && me.src[i] != 4'd15) begin
          if (mm.rw && mm.wa3 == me.src[i]) efwd[2*i +: 2] = 2'b10;
          else if (mw.rw && mw.wa3 == me.src[i]) efwd[2*i +: 2] = 2'b01;
        end
      end
      ld = 1'b0;
      for (int i = 0; i < 2; i++)
        if (me.rw && me.mr && d.sv[i] && d.src[i] == me.wa3 && d.src[i] != 4'd15) ld = 1'b1;
      pend = d.pcs || me.pcs || mm.pcs;
      est  = ld && !BranchTakenE;
      chk_outs("rnd", efwd, est || pend, est, pend || mw.pcs || BranchTakenE,
               ld || BranchTakenE, mw.pcs, 16'(mcnt));
      chk("rnd_cnt2", 32'(StallCount2), 32'(mcnt2));
      if (!rst_now) begin
        ne = d;
        if (ld || BranchTakenE) begin
          ne.rw = 1'b0; ne.mr = 1'b0; ne.pcs = 1'b0; ne.sv = 2'b00;
        end
        if (est || pend) begin
          if (mcnt < 65535) mcnt++;
          if (mcnt2 < 3) mcnt2++;
        end
        mw = mm; mm = me; me = ne;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
